// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive blocks: default word
// width, bit-order encoding and a counter-width helper.
package serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-order encoding shared with the transmit side: 1 = first bit is the MSB.
  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

  localparam bit DEFAULT_MSB_FIRST = 1'b1;

  // Bits needed to index 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Bit-position counter for the deserialiser: advances on enabled cycles,
// wraps after the last bit and restarts on a word-boundary resync.
module sipo_bitcnt
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic sync_i,
  output logic last_o
);

  localparam int unsigned     CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx;

  // A resync makes the bit sampled this cycle bit 0 of a fresh word.
  assign idx    = sync_i ? '0 : cnt_q;
  assign last_o = en_i && (idx == LAST_IDX);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (en_i) begin
      if (last_o) cnt_d = '0;
      else        cnt_d = idx + CW'(1);
    end else if (sync_i) begin
      cnt_d = '0;
    end
  end

  // NOTE: non-blocking assignments for all clocked state avoid update-order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sipo.sv
// Serial-in parallel-out receiver: shifts din in on enabled cycles and
// presents completed words on a registered dout with valid/ack handshake.
module sipo
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  input  logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] word;
  logic             last;

  sipo_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk    (clk),
    .rst_n  (rst),
    .en_i   (en),
    .sync_i (sync),
    .last_o (last)
  );

  // Partial bits are dropped on resync so the new word starts from a clean slate.
  assign base = sync ? '0 : shift_q;

  always_comb begin
    word = '0;
    if (MSB_FIRST == bit'(ORDER_MSB_FIRST)) word = {base[WIDTH-2:0], din};
    else                                    word = {din, base[WIDTH-1:1]};
  end

  always_comb begin
    shift_d   = en ? word : shift_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (last) begin
      // A pending word may only be replaced in the cycle it is acknowledged.
      if (!valid_q || ack) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ack) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the shift register is reset too, so a word cut short by reset leaves no residue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout    = dout_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo.sv
// Directed bench for sipo: per-cycle vector table for the MSB-first instance
// plus hand-written reset and LSB-first sequences.
module tb_sipo;

  logic       clk = 1'b0;
  logic       rst, din, en, sync, ack;
  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l, overrun_m, overrun_l;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       sync;
    logic       din;
    logic       ack;
    logic [7:0] dout;
    logic       valid;
    logic       ovr;
  } vec_t;

  vec_t vq[$];

  sipo #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync), .ack(ack),
    .dout(dout_m), .valid(valid_m), .overrun(overrun_m)
  );

  sipo #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync), .ack(ack),
    .dout(dout_l), .valid(valid_l), .overrun(overrun_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic s, input logic d, input logic a,
                     input logic [7:0] xd, input logic xv, input logic xo);
    vec_t v;
    v.en = e; v.sync = s; v.din = d; v.ack = a;
    v.dout = xd; v.valid = xv; v.ovr = xo;
    vq.push_back(v);
  endtask

  // One MSB-first word; optional sync on bit 0, ack on the last bit, and an
  // en=0 gap of `gap` cycles after bit 3.
  task automatic add_word(input logic [7:0] w, input logic sync_first, input logic ack_last,
                          input int gap,
                          input logic [7:0] d_mid, input logic v_mid, input logic o_mid,
                          input logic [7:0] d_end, input logic v_end, input logic o_end);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) add(1'b1, 1'b0, w[7-i], ack_last, d_end, v_end, o_end);
      else        add(1'b1, sync_first && (i == 0), w[7-i], 1'b0, d_mid, v_mid, o_mid);
      if (i == 3)
        for (int g = 0; g < gap; g++) add(1'b0, 1'b0, 1'b1, 1'b0, d_mid, v_mid, o_mid);
    end
  endtask

  task automatic send(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; din = w[7-i];
      @(negedge clk);
    end
    en = 1'b0; din = 1'b0;
  endtask

  initial begin
    logic [7:0] bits3;
    rst = 1'b0; din = 1'b0; en = 1'b0; sync = 1'b0; ack = 1'b0;

    // Basic word, hold without ack, ack, then ack while idle is ignored.
    add_word(8'hAA, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    // Back-to-back words, second completes together with ack.
    add_word(8'hAA, 1'b0, 1'b0, 0, 8'hAA, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0);
    add_word(8'h55, 1'b0, 1'b1, 0, 8'hAA, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    // Three stray bits, then resync with the start of C3.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    add_word(8'hC3, 1'b1, 1'b0, 0, 8'h55, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    // Same again with en low for three cycles mid-word.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, i[0], 1'b0, 8'hC3, 1'b0, 1'b0);
    add_word(8'hC3, 1'b1, 1'b0, 3, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    // Resync while disabled clears the count with nothing sampled.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    add_word(8'h81, 1'b0, 1'b0, 0, 8'hC3, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
    // Overrun: AA pending, 0F dropped; flag survives a later ack.
    add_word(8'hAA, 1'b0, 1'b0, 0, 8'h81, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0);
    add_word(8'h0F, 1'b0, 1'b0, 0, 8'hAA, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    check("reset dout", 32'(dout_m), 32'h0);
    check("reset valid", 32'(valid_m), 32'h0);
    check("reset overrun", 32'(overrun_m), 32'h0);
    rst = 1'b1;

    foreach (vq[i]) begin
      en = vq[i].en; sync = vq[i].sync; din = vq[i].din; ack = vq[i].ack;
      @(negedge clk);
      check($sformatf("row%0d dout", i), 32'(dout_m), 32'(vq[i].dout));
      check($sformatf("row%0d valid", i), 32'(valid_m), 32'(vq[i].valid));
      check($sformatf("row%0d overrun", i), 32'(overrun_m), 32'(vq[i].ovr));
    end
    en = 1'b0; sync = 1'b0; ack = 1'b0; din = 1'b0;

    // Asynchronous reset mid-word, between clock edges.
    bits3 = 8'b0000_0101;
    for (int i = 2; i >= 0; i--) begin
      en = 1'b1; din = bits3[i];
      @(negedge clk);
    end
    en = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("async rst dout", 32'(dout_m), 32'h0);
    check("async rst valid", 32'(valid_m), 32'h0);
    check("async rst overrun", 32'(overrun_m), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    send(8'h81);
    check("post-rst dout", 32'(dout_m), 32'h81);
    check("post-rst valid", 32'(valid_m), 32'h1);
    check("post-rst overrun", 32'(overrun_m), 32'h0);
    check("post-rst lsb dout", 32'(dout_l), 32'h81);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("post-rst ack valid", 32'(valid_m), 32'h0);

    // Serial 1,1,0,0,0,0,0,0: LSB-first gives 03, MSB-first gives C0.
    send(8'b1100_0000);
    check("lsb-first dout", 32'(dout_l), 32'h03);
    check("lsb-first valid", 32'(valid_l), 32'h1);
    check("msb-first same bits", 32'(dout_m), 32'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo.md
SIPO -- requirements
Module: sipo

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the parallel word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select bit order: 1 means the first received bit lands in dout[WIDTH-1]; 0 means it lands in dout[0].
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port din, input, 1 bit, SHALL be serial data, sampled on rising clk when en=1.
REQ-006 Port en, input, 1 bit, SHALL be the shift enable; en=0 pauses reception with all state held.
REQ-007 Port sync, input, 1 bit, SHALL be the word-boundary resync; the bit sampled in the same cycle is bit 0 of a new word.
REQ-008 Port ack, input, 1 bit, SHALL be the consumer acknowledge of the current dout word.
REQ-009 Port dout, output, WIDTH bits, SHALL be the registered parallel word.
REQ-010 Port valid, output, 1 bit, SHALL indicate that dout holds an unacknowledged word.
REQ-011 Port overrun, output, 1 bit, SHALL be the sticky flag for a lost word.

Function
REQ-012 Internal shift register and bit counter (0..WIDTH-1) SHALL advance only on cycles with en=1.
REQ-013 When sync=1 and en=1, the counter SHALL restart so the din bit sampled that cycle is bit 0, discarding any partial word.
REQ-014 When sync=1 and en=0, the counter SHALL clear with no bit sampled.
REQ-015 On the edge sampling bit WIDTH-1, the assembled word SHALL load into dout, valid SHALL rise on that same edge (latency 0 cycles after the last bit), and the counter SHALL wrap to 0.
REQ-016 Back-to-back words SHALL be received with no idle cycle between them.
REQ-017 valid SHALL stay high, and dout stable, until a cycle with ack=1; valid SHALL fall on that edge.
REQ-018 ack=1 while valid=0 SHALL be ignored.
REQ-019 If a word completes in the same cycle as ack=1 with valid=1, the new word SHALL load, valid SHALL remain 1, and overrun SHALL NOT set.
REQ-020 If a word completes while valid=1 and ack=0, the new word SHALL be dropped, dout SHALL retain the old word, and overrun SHALL set.
REQ-021 overrun SHALL remain set until reset.
REQ-022 Partial-word contents SHALL never appear on dout.

Reset
REQ-023 While rst=0: dout=0, valid=0, overrun=0, counter=0, shift register=0, asynchronously, irrespective of clk.
REQ-024 Reset asserted mid-word SHALL discard the partial word; the first enabled bit after release SHALL be bit 0.
REQ-025 Reset release SHALL be synchronous-safe: no state change on the release edge other than the normal clocked update.

Structure
REQ-026 The default WIDTH and the MSB_FIRST encoding SHALL live in shared package serial_pkg, which the transmit-side block also uses.
REQ-027 The bit counter with wrap and sync-clear SHALL be a sub-module, sipo_bitcnt; the shift register and output stage SHALL stay in sipo.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, en=1 held, serial 1,0,1,0,1,0,1,0 -> dout=8'hAA and valid=1 after the 8th edge; ack one cycle later -> valid=0.
REQ-029 MSB_FIRST=0, serial 1,1,0,0,0,0,0,0 -> dout=8'h03.
REQ-030 Two back-to-back words 8'hAA then 8'h55, with ack asserted in the completion cycle of the second word -> dout=8'h55, valid=1, overrun=0.
REQ-031 Word 8'hAA received, no ack, then word 8'h0F received -> dout=8'hAA, overrun=1; overrun stays 1 after a later ack.
REQ-032 Three bits sent, then sync=1 with the start of word 8'hC3 -> dout=8'hC3; en toggled low for 3 cycles mid-word -> same result.
REQ-033 rst pulsed low mid-word, asynchronous to clk -> all outputs 0 immediately; next full word 8'h81 -> dout=8'h81.
